input_sequencer: RTL and testbench
==================================

INPUT_SEQUENCER -- requirements
Module: input_sequencer

Interface
REQ-001 The module SHALL use exactly one clock, with a synchronous, active-high reset.
REQ-002 It SHALL have these ports (clock and reset first):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_key_data  in  5  key code from button scanner: {0,nnnn} matrix key, {10,ooo} op key
- i_key_valid  in  1  key code valid
- o_key_ready  out  1  key accepted when valid&&ready
- o_operand_a  out  16  signed two's-complement left operand to ALU
- o_operand_b  out  16  signed right operand to ALU
- o_alu_op  out  2  0 add, 1 sub, 2 mul, 3 div
- o_op_valid  out  1  ALU request valid
- i_op_ready  in  1  ALU accepts request
- i_result  in  16  signed ALU result
- i_result_err  in  1  ALU error (div-by-zero/overflow), qualified by i_result_valid
- i_result_valid  in  1  single-cycle result strobe
- o_display  out  16  signed value to show
- o_error  out  1  error indicator

Function
REQ-003 The FSM SHALL have exactly these states: ENTRY_A, ENTRY_B, ISSUE, WAIT_RES, RESULT, ERROR.
REQ-004 o_key_ready SHALL be 1 in ENTRY_A, ENTRY_B, RESULT and ERROR, and 0 in ISSUE and WAIT_RES.
REQ-005 A key SHALL be consumed on each cycle with i_key_valid&&o_key_ready; at most one key SHALL be consumed per cycle.
REQ-006 Digit keys 0..9 SHALL append to the active operand (op = op*10 ± d, sign preserved).
REQ-007 A 5th digit SHALL be consumed and ignored.
REQ-008 Matrix codes 10..15 and op code 7 SHALL be consumed and ignored.
REQ-009 NEG (op code 6) SHALL negate the active operand; negating 0 SHALL leave 0.
REQ-010 AC (op code 5) SHALL, in any key-accepting state, clear A, B, the digit count and the op, clear o_error, and go to ENTRY_A.
REQ-011 In ENTRY_A:
- an op key (0..3) SHALL latch the op, clear B and the digit count, and go to ENTRY_B;
- '=' (code 4) SHALL be ignored.
REQ-012 In ENTRY_B with digit count 0, an op key SHALL replace the latched op, and '=' SHALL be ignored.
REQ-013 In ENTRY_B with digit count >0:
- '=' SHALL go to ISSUE with the chain flag cleared;
- an op key SHALL store it as the chained op, set the chain flag, and go to ISSUE.
REQ-014 In ISSUE, o_op_valid SHALL be 1, with o_operand_a, o_operand_b and o_alu_op held stable until i_op_ready; on valid&&ready the FSM SHALL go to WAIT_RES on the next cycle.
REQ-015 o_op_valid SHALL be 0 in every state other than ISSUE.
REQ-016 In WAIT_RES, on i_result_valid:
- if i_result_err=1, go to ERROR;
- else A=i_result, and if the chain flag is set, op=chained op, B=0, count=0, go to ENTRY_B;
- else go to RESULT.
REQ-017 i_result_valid SHALL be ignored outside WAIT_RES.
REQ-018 In RESULT:
- a digit SHALL start a new A (A=d, count=1) and go to ENTRY_A;
- an op key SHALL use the result as A and go to ENTRY_B;
- NEG SHALL negate A;
- '=' SHALL be ignored.
REQ-019 In ERROR, every key except AC SHALL be consumed and ignored.
REQ-020 o_display SHALL show:
- B in ENTRY_B when count>0;
- 0 in ERROR;
- otherwise A.
REQ-021 o_error SHALL be 1 only in ERROR.
REQ-022 Outputs SHALL be registered or decoded from state only, with no combinational path from i_key_valid/i_result_valid to any output other than o_key_ready being state-based.

Reset
REQ-023 rst=1 at a clock edge SHALL force ENTRY_A, A=B=0, count=0, op=0, chain flag=0.
REQ-024 Reset SHALL force the outputs: o_op_valid=0, o_key_ready=1, o_display=0, o_error=0, o_operand_a=o_operand_b=0, o_alu_op=0.
REQ-025 Reset asserted in ISSUE or WAIT_RES SHALL abandon the request, and a later i_result_valid SHALL be ignored.

Verification
REQ-026 The bench SHALL cover at least these directed scenarios:
- Keys 1,2,+,3,= with ALU returning 15 -> ISSUE shows A=12, B=3, op=0; after result, RESULT with o_display=15.
- Keys 7,*,6,- (result 42), then 2,= (result 40) -> second request A=42, B=2, op=1; o_display=40.
- Keys 1,2,3,4,5 -> o_display=1234; then NEG -> -1234.
- Keys 9,/,0,= with i_result_err=1 -> ERROR, o_error=1, o_display=0; key 5 ignored; AC -> ENTRY_A, display 0.
- i_op_ready held 0 for 5 cycles in ISSUE -> o_op_valid and operands stable, o_key_ready=0, key presented is not consumed.
- Keys 5,+,- then 2,= -> op replaced: request is A=5, B=2, op=1.

Source files
------------

// File: rtl/input_sequencer.sv
// Calculator key sequencer: collects operands and an operator from scanned keys,
// issues ALU requests with a valid/ready handshake and tracks the displayed value.
module input_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_key_data,
    input  logic        i_key_valid,
    output logic        o_key_ready,
    output logic [15:0] o_operand_a,
    output logic [15:0] o_operand_b,
    output logic [1:0]  o_alu_op,
    output logic        o_op_valid,
    input  logic        i_op_ready,
    input  logic [15:0] i_result,
    input  logic        i_result_err,
    input  logic        i_result_valid,
    output logic [15:0] o_display,
    output logic        o_error
);

    // Handshakes: a key moves on a cycle with i_key_valid && o_key_ready; an ALU
    // request moves on o_op_valid && i_op_ready, operands held stable until then.
    localparam logic [2:0] ENTRY_A  = 3'd0;
    localparam logic [2:0] ENTRY_B  = 3'd1;
    localparam logic [2:0] ISSUE    = 3'd2;
    localparam logic [2:0] WAIT_RES = 3'd3;
    localparam logic [2:0] RESULT   = 3'd4;
    localparam logic [2:0] ERROR    = 3'd5;

    localparam logic [2:0] OPC_EQ  = 3'd4;
    localparam logic [2:0] OPC_AC  = 3'd5;
    localparam logic [2:0] OPC_NEG = 3'd6;

    logic [2:0]         state;
    logic signed [15:0] reg_a;
    logic signed [15:0] reg_b;
    logic [2:0]         digit_cnt;
    logic [1:0]         op;
    logic [1:0]         chain_op;
    logic               chain;

    logic       key_fire;
    logic       is_digit;
    logic       is_op;
    logic [2:0] opc;
    logic [3:0] digit;

    function automatic logic signed [15:0] append_digit(input logic signed [15:0] v,
                                                       input logic [3:0] d);
        logic signed [15:0] dx;
        logic signed [15:0] t;
        dx = $signed({12'd0, d});
        t  = v * 16'sd10;
        // Negative operands grow away from zero so the sign survives entry.
        return v[15] ? (t - dx) : (t + dx);
    endfunction

    assign o_key_ready = (state == ENTRY_A) || (state == ENTRY_B) ||
                         (state == RESULT)  || (state == ERROR);
    assign o_op_valid  = (state == ISSUE);
    assign o_error     = (state == ERROR);
    assign o_operand_a = reg_a;
    assign o_operand_b = reg_b;
    assign o_alu_op    = op;

    assign key_fire = i_key_valid && o_key_ready;
    assign digit    = i_key_data[3:0];
    assign opc      = i_key_data[2:0];
    assign is_digit = !i_key_data[4] && (i_key_data[3:0] < 4'd10);
    assign is_op    = (i_key_data[4:3] == 2'b10);

    always_comb begin
        o_display = reg_a;
        if (state == ERROR)
            o_display = 16'd0;
        else if ((state == ENTRY_B) && (digit_cnt != 3'd0))
            o_display = reg_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ENTRY_A;
            reg_a     <= 16'sd0;
            reg_b     <= 16'sd0;
            digit_cnt <= 3'd0;
            op        <= 2'd0;
            chain_op  <= 2'd0;
            chain     <= 1'b0;
        end else if (key_fire && is_op && (opc == OPC_AC)) begin
            state     <= ENTRY_A;
            reg_a     <= 16'sd0;
            reg_b     <= 16'sd0;
            digit_cnt <= 3'd0;
            op        <= 2'd0;
            chain     <= 1'b0;
        end else begin
            case (state)
                ENTRY_A: begin
                    if (key_fire && is_digit && (digit_cnt < 3'd4)) begin
                        reg_a     <= append_digit(reg_a, digit);
                        digit_cnt <= digit_cnt + 3'd1;
                    end else if (key_fire && is_op && (opc == OPC_NEG)) begin
                        reg_a <= -reg_a;
                    end else if (key_fire && is_op && !opc[2]) begin
                        op        <= opc[1:0];
                        reg_b     <= 16'sd0;
                        digit_cnt <= 3'd0;
                        state     <= ENTRY_B;
                    end
                end
                ENTRY_B: begin
                    if (key_fire && is_digit && (digit_cnt < 3'd4)) begin
                        reg_b     <= append_digit(reg_b, digit);
                        digit_cnt <= digit_cnt + 3'd1;
                    end else if (key_fire && is_op && (opc == OPC_NEG)) begin
                        reg_b <= -reg_b;
                    end else if (key_fire && is_op && !opc[2]) begin
                        // With no B digits yet, a new operator just corrects the old one.
                        if (digit_cnt == 3'd0) begin
                            op <= opc[1:0];
                        end else begin
                            chain_op <= opc[1:0];
                            chain    <= 1'b1;
                            state    <= ISSUE;
                        end
                    end else if (key_fire && is_op && (opc == OPC_EQ) &&
                                 (digit_cnt != 3'd0)) begin
                        chain <= 1'b0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_op_ready)
                        state <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (i_result_valid) begin
                        if (i_result_err) begin
                            state <= ERROR;
                        end else begin
                            reg_a <= i_result;
                            if (chain) begin
                                op        <= chain_op;
                                reg_b     <= 16'sd0;
                                digit_cnt <= 3'd0;
                                state     <= ENTRY_B;
                            end else begin
                                state <= RESULT;
                            end
                        end
                    end
                end
                RESULT: begin
                    if (key_fire && is_digit) begin
                        reg_a     <= $signed({12'd0, digit});
                        digit_cnt <= 3'd1;
                        state     <= ENTRY_A;
                    end else if (key_fire && is_op && (opc == OPC_NEG)) begin
                        reg_a <= -reg_a;
                    end else if (key_fire && is_op && !opc[2]) begin
                        op        <= opc[1:0];
                        reg_b     <= 16'sd0;
                        digit_cnt <= 3'd0;
                        state     <= ENTRY_B;
                    end
                end
                ERROR: begin
                end
                default: state <= ENTRY_A;
            endcase
        end
    end

endmodule

// File: tb/tb_input_sequencer.sv
// Directed bench for input_sequencer: key sequences with hand-computed operands,
// ALU requests and display values.
module tb_input_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  i_key_data;
    logic        i_key_valid;
    logic        o_key_ready;
    logic [15:0] o_operand_a;
    logic [15:0] o_operand_b;
    logic [1:0]  o_alu_op;
    logic        o_op_valid;
    logic        i_op_ready;
    logic [15:0] i_result;
    logic        i_result_err;
    logic        i_result_valid;
    logic [15:0] o_display;
    logic        o_error;

    int tests  = 0;
    int errors = 0;

    localparam logic [4:0] K_ADD = 5'd16;
    localparam logic [4:0] K_SUB = 5'd17;
    localparam logic [4:0] K_MUL = 5'd18;
    localparam logic [4:0] K_DIV = 5'd19;
    localparam logic [4:0] K_EQ  = 5'd20;
    localparam logic [4:0] K_AC  = 5'd21;
    localparam logic [4:0] K_NEG = 5'd22;
    localparam logic [4:0] K_NOP = 5'd23;

    input_sequencer dut (
        .clk(clk), .rst(rst),
        .i_key_data(i_key_data), .i_key_valid(i_key_valid), .o_key_ready(o_key_ready),
        .o_operand_a(o_operand_a), .o_operand_b(o_operand_b), .o_alu_op(o_alu_op),
        .o_op_valid(o_op_valid), .i_op_ready(i_op_ready),
        .i_result(i_result), .i_result_err(i_result_err), .i_result_valid(i_result_valid),
        .o_display(o_display), .o_error(o_error)
    );

    always #5 clk = ~clk;

    task automatic send_key(input logic [4:0] code);
        int n;
        n = 0;
        @(negedge clk);
        i_key_data  = code;
        i_key_valid = 1'b1;
        while (!o_key_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tests++; errors++;
            $display("FAIL key_ready_timeout: code=%0d never accepted", code);
        end
        @(posedge clk);
        #1;
        i_key_valid = 1'b0;
    endtask

    task automatic check_display(input string name, input logic [15:0] exp);
        @(negedge clk);
        tests++;
        if (o_display !== exp) begin
            errors++;
            $display("FAIL %s: o_display=%0d expected %0d", name, $signed(o_display), $signed(exp));
        end
    endtask

    // Acts as the ALU: checks the request, accepts it, then returns a result.
    task automatic alu_respond(input string name, input logic [15:0] ea, input logic [15:0] eb,
                               input logic [1:0] eop, input logic [15:0] res, input logic err);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_op_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!o_op_valid) begin
            errors++;
            $display("FAIL %s_op_valid: o_op_valid=0 expected 1", name);
        end
        tests++;
        if (o_operand_a !== ea) begin
            errors++;
            $display("FAIL %s_operand_a: got %0d expected %0d", name, $signed(o_operand_a), $signed(ea));
        end
        tests++;
        if (o_operand_b !== eb) begin
            errors++;
            $display("FAIL %s_operand_b: got %0d expected %0d", name, $signed(o_operand_b), $signed(eb));
        end
        tests++;
        if (o_alu_op !== eop) begin
            errors++;
            $display("FAIL %s_alu_op: got %0d expected %0d", name, o_alu_op, eop);
        end
        tests++;
        if (o_key_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_key_ready_issue: got %b expected 0", name, o_key_ready);
        end
        i_op_ready = 1'b1;
        @(posedge clk);
        #1;
        i_op_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (o_op_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_op_valid_wait: got %b expected 0", name, o_op_valid);
        end
        i_result       = res;
        i_result_err   = err;
        i_result_valid = 1'b1;
        @(posedge clk);
        #1;
        i_result_valid = 1'b0;
        i_result_err   = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests += 7;
        if (o_op_valid !== 1'b0)   begin errors++; $display("FAIL rst_op_valid: got %b expected 0", o_op_valid); end
        if (o_key_ready !== 1'b1)  begin errors++; $display("FAIL rst_key_ready: got %b expected 1", o_key_ready); end
        if (o_display !== 16'd0)   begin errors++; $display("FAIL rst_display: got %0d expected 0", o_display); end
        if (o_error !== 1'b0)      begin errors++; $display("FAIL rst_error: got %b expected 0", o_error); end
        if (o_operand_a !== 16'd0) begin errors++; $display("FAIL rst_operand_a: got %0d expected 0", o_operand_a); end
        if (o_operand_b !== 16'd0) begin errors++; $display("FAIL rst_operand_b: got %0d expected 0", o_operand_b); end
        if (o_alu_op !== 2'd0)     begin errors++; $display("FAIL rst_alu_op: got %0d expected 0", o_alu_op); end
    endtask

    task automatic test_add();
        send_key(5'd1); send_key(5'd2); send_key(K_ADD);
        check_display("add_display_a_after_op", 16'd12);
        send_key(5'd3);
        check_display("add_display_b", 16'd3);
        send_key(K_EQ);
        alu_respond("add", 16'd12, 16'd3, 2'd0, 16'd15, 1'b0);
        check_display("add_result", 16'd15);
        tests++;
        if (o_key_ready !== 1'b1) begin
            errors++; $display("FAIL add_key_ready_result: got %b expected 1", o_key_ready);
        end
    endtask

    task automatic test_chain();
        send_key(5'd7); send_key(K_MUL); send_key(5'd6); send_key(K_SUB);
        alu_respond("chain1", 16'd7, 16'd6, 2'd2, 16'd42, 1'b0);
        check_display("chain_intermediate", 16'd42);
        send_key(5'd2); send_key(K_EQ);
        alu_respond("chain2", 16'd42, 16'd2, 2'd1, 16'd40, 1'b0);
        check_display("chain_result", 16'd40);
    endtask

    task automatic test_digits();
        send_key(K_AC);
        send_key(K_NEG);
        check_display("neg_zero", 16'd0);
        send_key(5'd1); send_key(5'd2); send_key(5'd3); send_key(5'd4); send_key(5'd5);
        check_display("fifth_digit_ignored", 16'd1234);
        send_key(5'd12); send_key(K_NOP);
        check_display("ignored_codes", 16'd1234);
        send_key(K_NEG);
        check_display("neg_1234", -16'sd1234);
    endtask

    task automatic test_error();
        send_key(K_AC);
        send_key(5'd9); send_key(K_DIV); send_key(5'd0); send_key(K_EQ);
        alu_respond("div0", 16'd9, 16'd0, 2'd3, 16'd0, 1'b1);
        @(negedge clk);
        tests += 2;
        if (o_error !== 1'b1)    begin errors++; $display("FAIL err_flag: got %b expected 1", o_error); end
        if (o_key_ready !== 1'b1) begin errors++; $display("FAIL err_key_ready: got %b expected 1", o_key_ready); end
        check_display("err_display", 16'd0);
        send_key(5'd5);
        check_display("err_digit_ignored", 16'd0);
        tests++;
        if (o_error !== 1'b1) begin errors++; $display("FAIL err_after_digit: got %b expected 1", o_error); end
        send_key(K_AC);
        @(negedge clk);
        tests++;
        if (o_error !== 1'b0) begin errors++; $display("FAIL ac_clears_error: got %b expected 0", o_error); end
        check_display("ac_display", 16'd0);
        send_key(5'd4);
        check_display("entry_after_ac", 16'd4);
    endtask

    task automatic test_stall();
        send_key(K_AC);
        send_key(5'd8); send_key(K_SUB); send_key(5'd1); send_key(K_EQ);
        @(negedge clk);
        i_key_data  = 5'd3;
        i_key_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (o_op_valid !== 1'b1 || o_operand_a !== 16'd8 || o_operand_b !== 16'd1 ||
                o_alu_op !== 2'd1 || o_key_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d: valid=%b a=%0d b=%0d op=%0d ready=%b expected 1/8/1/1/0",
                         i, o_op_valid, o_operand_a, o_operand_b, o_alu_op, o_key_ready);
            end
        end
        i_key_valid = 1'b0;
        alu_respond("stall", 16'd8, 16'd1, 2'd1, 16'd7, 1'b0);
        check_display("stall_result", 16'd7);
    endtask

    task automatic test_replace_op();
        send_key(K_AC);
        send_key(5'd5); send_key(K_ADD); send_key(K_SUB);
        send_key(K_EQ);
        check_display("eq_ignored_no_b", 16'd5);
        send_key(5'd2); send_key(K_EQ);
        alu_respond("replace", 16'd5, 16'd2, 2'd1, 16'd3, 1'b0);
        check_display("replace_result", 16'd3);
    endtask

    task automatic test_result_keys();
        send_key(K_NEG);
        check_display("result_neg", -16'sd3);
        send_key(K_EQ);
        check_display("result_eq_ignored", -16'sd3);
        send_key(K_ADD); send_key(5'd4); send_key(K_EQ);
        alu_respond("result_as_a", -16'sd3, 16'd4, 2'd0, 16'd1, 1'b0);
        check_display("result_as_a_out", 16'd1);
    endtask

    task automatic test_reset_abandon();
        send_key(K_AC);
        send_key(5'd3); send_key(K_ADD); send_key(5'd4); send_key(K_EQ);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests += 2;
        if (o_op_valid !== 1'b0)  begin errors++; $display("FAIL abandon_op_valid: got %b expected 0", o_op_valid); end
        if (o_key_ready !== 1'b1) begin errors++; $display("FAIL abandon_key_ready: got %b expected 1", o_key_ready); end
        i_result       = 16'd99;
        i_result_valid = 1'b1;
        @(posedge clk);
        #1;
        i_result_valid = 1'b0;
        check_display("abandon_result_ignored", 16'd0);
        send_key(5'd5);
        check_display("abandon_entry_a", 16'd5);
    endtask

    initial begin
        rst            = 1'b1;
        i_key_data     = 5'd0;
        i_key_valid    = 1'b0;
        i_op_ready     = 1'b0;
        i_result       = 16'd0;
        i_result_err   = 1'b0;
        i_result_valid = 1'b0;
        test_reset();
        test_add();
        test_chain();
        test_digits();
        test_error();
        test_stall();
        test_replace_op();
        test_result_keys();
        test_reset_abandon();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
